tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a TDM link carried over the 4:1 channel-select mux interface (channels A, B, C, D, selected by {S1,S0}). It accepts one sample per valid cycle on a shared input, tracks the slot position from a frame-sync marker, and presents all four channels as parallel registered outputs once per complete frame. It sits after the link input and feeds per-channel consumers. It flags sync loss and misaligned frames.

## Interface
- W, default 1: sample width in bits, per channel and on din; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  multiplexed sample; sampled only when din_valid=1.
- din_valid  input  1  din carries a sample this cycle.
- sync  input  1  marks the din sample as slot 0 (channel A); ignored when din_valid=0.
- A, B, C, D  output  W each  registered channel samples from the last complete frame.
- S1, S0  output  1 each  slot index {S1,S0} expected for the next accepted sample: 0=A, 1=B, 2=C, 3=D.
- frame_valid  output  1  one-cycle pulse; A..D updated this cycle.
- locked  output  1  1 while state is LOCKED.
- sync_err  output  1  one-cycle pulse on sync protocol violation.

## Operation
- States: HUNT and LOCKED. Slot counter is 2 bits and drives {S1,S0}. Shadow registers shA, shB, shC are W bits each.
- HUNT:
  - Samples with din_valid=1 and sync=0 are discarded. The slot counter holds at 0.
  - A sample with din_valid=1 and sync=1 is stored in shA. The counter goes to 1 and the state goes to LOCKED.
- LOCKED, accepted sample (din_valid=1), by counter value:
  - Counter 0 with sync=1: store in shA; counter goes to 1.
  - Counter 0 with sync=0 (missing sync): pulse sync_err, discard the sample and the partial frame, go to HUNT, counter goes to 0.
  - Counter 1 or 2 with sync=0: store in shB or shC; counter increments.
  - Counter 3 with sync=0: load A<=shA, B<=shB, C<=shC, D<=din together, pulse frame_valid, counter wraps to 0.
  - Counter 1, 2 or 3 with sync=1 (early sync): pulse sync_err, drop the partial frame, store din in shA, counter goes to 1, stay LOCKED.
- din_valid=0: no state, counter or shadow change; gaps of any length are allowed anywhere in a frame.
- A..D change only on frame completion. They hold their values through HUNT, sync errors and gaps.
- sync_err and frame_valid are never asserted in the same cycle.
- Channel order within a frame is fixed: A, B, C, D, matching select codes 00, 01, 10, 11.

## Timing
- Reset (rst_n=0, asynchronous, immediate):
  - A=B=C=D=0, S1=S0=0, frame_valid=0, sync_err=0, locked=0.
  - State goes to HUNT; shadows are cleared to 0.
- Deassertion of rst_n takes effect at the next rising clk edge. Input is sampled from the first edge with rst_n=1.
- Reset mid-frame discards all partial data. The next frame requires sync.
- All outputs are registered. There is no combinational path from input to output.
- Latency: A..D and frame_valid update at the clk edge that samples the slot-3 sample, and are visible for the following cycle. frame_valid is high for exactly one cycle per frame.
- sync_err: registered, one cycle high, asserted after the edge that samples the offending sample.
- locked: falls in the same cycle that sync_err is asserted for a missing sync. It rises after the edge that accepts a sync sample in HUNT.
- {S1,S0} updates after each accepted sample.
- Peak throughput: one frame per 4 consecutive valid cycles, with back-to-back frames and no idle cycle required.

## Test plan
- Reset, then a single frame: with W=4, send din=1 (sync=1), 2, 3, 4 on 4 consecutive valid cycles -> A=1, B=2, C=3, D=4, frame_valid pulses once, locked=1, sync_err=0.
- Gaps and back-to-back frames: send frame 5,6,7,8 with din_valid=0 gaps of 0-3 cycles between samples, then frame 9,10,11,12 immediately after -> two frame_valid pulses; A..D = 5..8 and then 9..12; {S1,S0} sequence 1,2,3,0,1,2,3,0.
- Early sync: send 1 (sync), 2, then 7 with sync=1, then 8, 9, 10 -> sync_err pulses after sample 7; the next frame gives A=7, B=8, C=9, D=10; locked stays 1.
- Missing sync and re-hunt: complete a frame, then send slot-0 sample 3 with sync=0 -> sync_err pulses, locked=0, A..D unchanged; samples without sync are discarded; a sync sample relocks.
- Async reset mid-frame: after samples 1 (sync) and 2, pull rst_n low between clock edges -> all outputs are 0 immediately; after release, samples without sync are ignored until sync.
- Data width sweep: for W=1 and W=32, frames with all-ones and alternating patterns -> exact per-channel match and no bit crosstalk between channels.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Bus bundle for the TDM demultiplexer: multiplexed sample input side and
// per-channel frame output side.
interface tdm_demux4_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sync;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic         S1;
    logic         S0;
    logic         frame_valid;
    logic         locked;
    logic         sync_err;

    modport master (
        output din, din_valid, sync,
        input  A, B, C, D, S1, S0, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output A, B, C, D, S1, S0, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: tracks slot position from a frame-sync marker and
// publishes channels A..D in parallel once per complete frame.
module tdm_demux4 #(
    parameter int unsigned W = 1
) (
    input logic        clk,
    input logic        rst_n,
    tdm_demux4_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t       state, state_d;
    logic [1:0]   slot, slot_d;
    logic [W-1:0] sha, shb, shc;
    logic [W-1:0] sha_d, shb_d, shc_d;
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic         load;
    logic         err;
    logic         fv_q;
    logic         err_q;

    always_comb begin
        state_d = state;
        slot_d  = slot;
        sha_d   = sha;
        shb_d   = shb;
        shc_d   = shc;
        load    = 1'b0;
        err     = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.sync) begin
                        sha_d   = bus.din;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    // A sync always restarts the frame; only off slot 0 is it an error.
                    if (bus.sync) begin
                        err    = (slot != 2'd0);
                        sha_d  = bus.din;
                        slot_d = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                err     = 1'b1;
                                state_d = HUNT;
                                slot_d  = 2'd0;
                            end
                            2'd1: begin
                                shb_d  = bus.din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                shc_d  = bus.din;
                                slot_d = 2'd3;
                            end
                            default: begin
                                load   = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= '0;
            sha   <= '0;
            shb   <= '0;
            shc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            fv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            slot  <= slot_d;
            sha   <= sha_d;
            shb   <= shb_d;
            shc   <= shc_d;
            fv_q  <= load;
            err_q <= err;
            if (load) begin
                a_q <= sha;
                b_q <= shb;
                c_q <= shc;
                d_q <= bus.din;
            end
        end
    end

    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.C           = c_q;
    assign bus.D           = d_q;
    assign bus.S1          = slot[1];
    assign bus.S0          = slot[0];
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = err_q;
    assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 at W=4, W=1 and W=32 driven in lockstep.
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux4_if #(.W(4))  b4();
    tdm_demux4_if #(.W(1))  b1();
    tdm_demux4_if #(.W(32)) b32();

    tdm_demux4 #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    tdm_demux4 #(.W(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    tdm_demux4 #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } frame_t;

    frame_t      q[$];
    int          total = 0;
    int          bad = 0;
    logic        m_locked;
    logic [1:0]  m_slot;
    logic [31:0] sh0, sh1, sh2;
    logic [31:0] mo[4];
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        b4.din = d[3:0];  b1.din = d[0];  b32.din = d;
        b4.din_valid = v; b1.din_valid = v; b32.din_valid = v;
        b4.sync = s;      b1.sync = s;      b32.sync = s;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_slot = 2'd0;
        sh0 = '0; sh1 = '0; sh2 = '0;
        for (int i = 0; i < 4; i++) mo[i] = '0;
        m_err = 1'b0;
        q.delete();
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_A4"}, {28'b0, b4.A}, {28'b0, mo[0][3:0]});
        chk({tag, "_B4"}, {28'b0, b4.B}, {28'b0, mo[1][3:0]});
        chk({tag, "_C4"}, {28'b0, b4.C}, {28'b0, mo[2][3:0]});
        chk({tag, "_D4"}, {28'b0, b4.D}, {28'b0, mo[3][3:0]});
        chk({tag, "_ABCD1"}, {28'b0, b1.A, b1.B, b1.C, b1.D},
            {28'b0, mo[0][0], mo[1][0], mo[2][0], mo[3][0]});
        chk({tag, "_A32"}, b32.A, mo[0]);
        chk({tag, "_B32"}, b32.B, mo[1]);
        chk({tag, "_C32"}, b32.C, mo[2]);
        chk({tag, "_D32"}, b32.D, mo[3]);
    endtask

    task automatic chk_ctl(input string tag);
        chk({tag, "_err"}, {31'b0, b4.sync_err}, {31'b0, m_err});
        chk({tag, "_err32"}, {31'b0, b32.sync_err}, {31'b0, m_err});
        chk({tag, "_locked"}, {31'b0, b4.locked}, {31'b0, m_locked});
        chk({tag, "_slot"}, {30'b0, b4.S1, b4.S0}, {30'b0, m_slot});
    endtask

    // Reference behaviour of one accepted sample.
    task automatic model_step(input logic [31:0] d, input logic s);
        frame_t f;
        m_err = 1'b0;
        if (!m_locked) begin
            if (s) begin
                sh0 = d; m_slot = 2'd1; m_locked = 1'b1;
            end
        end else if (s) begin
            m_err = (m_slot != 2'd0);
            sh0 = d;
            m_slot = 2'd1;
        end else if (m_slot == 2'd0) begin
            m_err = 1'b1; m_locked = 1'b0;
        end else if (m_slot == 2'd1) begin
            sh1 = d; m_slot = 2'd2;
        end else if (m_slot == 2'd2) begin
            sh2 = d; m_slot = 2'd3;
        end else begin
            f.a = sh0; f.b = sh1; f.c = sh2; f.d = d;
            mo[0] = sh0; mo[1] = sh1; mo[2] = sh2; mo[3] = d;
            q.push_back(f);
            m_slot = 2'd0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s);
        @(negedge clk);
        drive(1'b1, s, d);
        @(posedge clk);
        #1;
        model_step(d, s);
        drive(1'b0, 1'b0, d);
        chk_ctl("send");
        chk_outs("send");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
            @(posedge clk);
            #1;
            m_err = 1'b0;
            chk_ctl("idle");
            chk_outs("idle");
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        m_err = 1'b0;
        chk_ctl(tag);
        chk_outs(tag);
        chk({tag, "_fv"}, {29'b0, b4.frame_valid, b1.frame_valid, b32.frame_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (b4.frame_valid || b1.frame_valid || b32.frame_valid)) begin
            if (q.size() == 0) begin
                chk("fv_spurious", 32'd1, 32'd0);
            end else begin
                frame_t f;
                f = q.pop_front();
                chk("fv", {29'b0, b4.frame_valid, b1.frame_valid, b32.frame_valid}, 32'd7);
                chk("sb_err", {31'b0, b4.sync_err}, 32'd0);
                chk("sb_4", {16'b0, b4.A, b4.B, b4.C, b4.D},
                    {16'b0, f.a[3:0], f.b[3:0], f.c[3:0], f.d[3:0]});
                chk("sb_1", {28'b0, b1.A, b1.B, b1.C, b1.D},
                    {28'b0, f.a[0], f.b[0], f.c[0], f.d[0]});
                chk("sb_A32", b32.A, f.a);
                chk("sb_B32", b32.B, f.b);
                chk("sb_C32", b32.C, f.c);
                chk("sb_D32", b32.D, f.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, '0);
        model_reset();
        #1;
        chk_reset_outs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // single frame
        send(1, 1); send(2, 0); send(3, 0); send(4, 0);

        // gaps then back-to-back frame
        send(5, 1); idle(1); send(6, 0); idle(3); send(7, 0); idle(2); send(8, 0);
        send(9, 1); send(10, 0); send(11, 0); send(12, 0);

        // early sync at slot 2 and at slot 3
        send(1, 1); send(2, 0); send(7, 1); send(8, 0); send(9, 0); send(10, 0);
        send(1, 1); send(2, 0); send(3, 0); send(50, 1); send(51, 0); send(52, 0); send(53, 0);

        // missing sync, discarded samples, relock
        send(3, 0); send(5, 0); idle(1); send(6, 0);
        send(20, 1); send(21, 0); send(22, 0); send(23, 0);

        // asynchronous reset mid-frame
        send(1, 1); send(2, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outs("rst_mid");
        @(posedge clk);
        #1;
        chk_reset_outs("rst_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 0); send(4, 0);
        send(40, 1); send(41, 0); send(42, 0); send(43, 0);

        // width / crosstalk patterns
        send(32'hFFFF_FFFF, 1); send(32'hFFFF_FFFF, 0); send(32'hFFFF_FFFF, 0); send(32'hFFFF_FFFF, 0);
        send(32'hAAAA_AAAA, 1); send(32'h5555_5555, 0); send(32'hAAAA_AAAA, 0); send(32'h5555_5555, 0);
        send(32'hFFFF_FFFF, 1); send(32'h0000_0000, 0); send(32'hFFFF_FFFF, 0); send(32'h0000_0000, 0);
        send(32'h0000_0000, 1); send(32'hFFFF_FFFF, 0); send(32'h0000_0000, 0); send(32'hFFFF_FFFF, 0);
        for (int k = 0; k < 3; k++) begin
            send($urandom, 1); send($urandom, 0); send($urandom, 0); send($urandom, 0);
        end

        idle(2);
        chk("q_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
